// File: rtl/apb_initiator_pkg.sv
// Shared types and defaults for the APB4 requester and its watchdog.
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_BUS_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_NTARGETS   = 1;
  localparam int DEF_TIMEOUT    = 256;
  localparam int MAX_DIM        = 16;

  // clog2 that never returns a zero-width result
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_wdog_cnt.sv
// ACCESS-phase watchdog: counts stalled cycles, flags the last permitted one.
module apb_wdog_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i)  cnt <= cnt + CNT_W'(1);
  end

  // limit of zero disables the watchdog entirely
  assign expired_o = (limit_i != '0) && (cnt == limit_i - CNT_W'(1));

endmodule

// File: rtl/apb_initiator.sv
// APB4 requester: one valid/ready command in, one SETUP/ACCESS transfer out, one response pulse back.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter  int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter  int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter  int NTARGETS       = DEF_NTARGETS,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT,
  localparam int STRB_W         = BUS_WIDTH / 8,
  localparam int TGT_W          = clog2_min1(NTARGETS),
  localparam int CNT_W          = clog2_min1(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_W-1:0]     cmd_strb_i,
  input  logic [TGT_W-1:0]      cmd_tgt_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [NTARGETS-1:0]   psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_W-1:0]     pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  apb_state_e          state;
  logic                bad_pend;
  logic                accept;
  logic                tgt_ok;
  logic                wdog_exp;
  logic [NTARGETS-1:0] sel_dec;

  for (genvar g = 0; g < NTARGETS; g++) begin : g_sel
    assign sel_dec[g] = (cmd_tgt_i == TGT_W'(g));
  end

  assign tgt_ok = ({1'b0, cmd_tgt_i} < (TGT_W + 1)'(NTARGETS));

  // A bad-target command accepted on a completion edge owes its error response one
  // cycle later; hold off new commands until that pulse has gone out.
  assign cmd_ready_o = ((state == ST_IDLE) && !bad_pend) || ((state == ST_ACCESS) && pready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;

  apb_wdog_cnt #(.CNT_W(CNT_W)) u_wdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state == ST_SETUP),
    .en_i      ((state == ST_ACCESS) && !pready_i),
    .limit_i   (CNT_W'(TIMEOUT_CYCLES)),
    .expired_o (wdog_exp)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      bad_pend      <= 1'b0;
      psel_o        <= '0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (bad_pend) begin
        rsp_valid_o   <= 1'b1;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b0;
        rsp_rdata_o   <= '0;
        bad_pend      <= 1'b0;
      end
      case (state)
        ST_SETUP: begin
          penable_o <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            psel_o        <= '0;
            penable_o     <= 1'b0;
            state         <= ST_IDLE;
          end else if (wdog_exp) begin
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= '0;
            psel_o        <= '0;
            penable_o     <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: ;
      endcase
      // A new command overrides the return-to-idle above, keeping psel high into SETUP.
      if (accept) begin
        if (tgt_ok) begin
          state     <= ST_SETUP;
          psel_o    <= sel_dec;
          penable_o <= 1'b0;
          pwrite_o  <= cmd_write_i;
          paddr_o   <= cmd_addr_i;
          pwdata_o  <= cmd_wdata_i;
          pstrb_o   <= cmd_write_i ? cmd_strb_i : '0;
        end else if (state == ST_IDLE) begin
          rsp_valid_o   <= 1'b1;
          rsp_err_o     <= 1'b1;
          rsp_timeout_o <= 1'b0;
          rsp_rdata_o   <= '0;
        end else begin
          bad_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: scoreboard queue of expected responses, negedge monitor.
module tb_apb_initiator;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NT = 1;
  localparam int TO = 4;
  localparam int SW = BW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [0:0]    cmd_tgt;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [BW-1:0] rsp_rdata;
  logic [NT-1:0] psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [BW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;
  logic [BW-1:0] prdata;

  always #5 clk = ~clk;

  apb_initiator #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NTARGETS(NT), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb), .cmd_tgt_i(cmd_tgt),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );

  typedef struct packed {
    logic [BW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t exp_r;
  int   checks = 0;
  int   errors = 0;

  logic [BW-1:0] b2b_d [4] = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                                64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input logic [BW-1:0] d, input logic e, input logic t);
    sb_q.push_back('{rdata: d, err: e, tmo: t});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                     input logic [SW-1:0] s, input logic [0:0] t);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_tgt   = t;
  endtask

  // monitor: every response pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        exp_r = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, exp_r.rdata);
        chk("rsp_err", 64'(rsp_err), 64'(exp_r.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_r.tmo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    cmd_tgt = '0; pready = 1'b1; pslverr = 1'b0; prdata = '0;

    #12;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // zero-wait write
    cmd(1'b1, 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    exp_rsp(64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wr_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wr_setup_psel", 64'(psel), 64'd1);
    chk("wr_setup_penable", 64'(penable), 64'd0);
    chk("wr_setup_paddr", 64'(paddr), 64'h10);
    chk("wr_setup_pwdata", pwdata, 64'h0123_4567_89AB_CDEF);
    chk("wr_setup_pstrb", 64'(pstrb), 64'hFF);
    chk("wr_setup_pwrite", 64'(pwrite), 64'd1);
    @(negedge clk);
    chk("wr_access_penable", 64'(penable), 64'd1);
    chk("wr_access_psel", 64'(psel), 64'd1);
    chk("wr_access_paddr", 64'(paddr), 64'h10);
    chk("wr_access_pwdata", pwdata, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("wr_rsp_latency", 64'(rsp_valid), 64'd1);
    chk("wr_bus_idle", 64'(psel), 64'd0);

    // read with two wait states; strobes must be masked
    step();
    pready = 1'b0;
    cmd(1'b0, 32'h20, 64'hFFFF, 8'hFF, 1'b0);
    exp_rsp(64'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rd_setup_pstrb", 64'(pstrb), 64'd0);
    chk("rd_setup_pwrite", 64'(pwrite), 64'd0);
    chk("rd_setup_paddr", 64'(paddr), 64'h20);
    @(negedge clk);
    chk("rd_wait1_penable", 64'(penable), 64'd1);
    @(negedge clk);
    chk("rd_wait2_penable", 64'(penable), 64'd1);
    chk("rd_wait2_no_rsp", 64'(rsp_valid), 64'd0);
    step();
    pready = 1'b1;
    prdata = 64'hDEAD_BEEF;
    step();
    @(negedge clk);
    chk("rd_rsp_latency", 64'(rsp_valid), 64'd1);
    prdata = '0;

    // back-to-back writes with cmd_valid held
    step();
    cmd(1'b1, 32'h100, b2b_d[0], 8'h0F, 1'b0);
    for (int k = 0; k < 4; k++) exp_rsp(64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_ready_idle", 64'(cmd_ready), 64'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cmd(1'b1, 32'h100 + 32'(8 * (k + 1)), b2b_d[k+1], 8'h0F, 1'b0);
      else cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_setup_ready", 64'(cmd_ready), 64'd0);
      chk("b2b_setup_psel", 64'(psel), 64'd1);
      chk("b2b_setup_penable", 64'(penable), 64'd0);
      chk("b2b_setup_pwdata", pwdata, b2b_d[k]);
      chk("b2b_setup_paddr", 64'(paddr), 64'(32'h100 + 32'(8 * k)));
      @(negedge clk);
      chk("b2b_access_ready", 64'(cmd_ready), 64'd1);
      chk("b2b_access_psel", 64'(psel), 64'd1);
      chk("b2b_access_penable", 64'(penable), 64'd1);
      step();
    end
    @(negedge clk);
    chk("b2b_end_psel", 64'(psel), 64'd0);

    // slave error on a write
    step();
    pslverr = 1'b1;
    cmd(1'b1, 32'h40, 64'h1, 8'h01, 1'b0);
    exp_rsp(64'h0, 1'b1, 1'b0);
    step();
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("slverr_rsp_latency", 64'(rsp_valid), 64'd1);
    step();
    pslverr = 1'b0;
    @(negedge clk);
    chk("slverr_hold_err", 64'(rsp_err), 64'd1);
    chk("slverr_pulse_1cyc", 64'(rsp_valid), 64'd0);

    // watchdog expiry after TO access cycles
    step();
    pready = 1'b0;
    prdata = 64'h5555;
    cmd(1'b0, 32'h30, 64'h0, 8'h00, 1'b0);
    exp_rsp(64'h0, 1'b1, 1'b1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("to_setup_penable", 64'(penable), 64'd0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_access_penable", 64'(penable), 64'd1);
      chk("to_access_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("to_idle_psel", 64'(psel), 64'd0);
    chk("to_idle_penable", 64'(penable), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);

    // pready on the last watchdog cycle completes normally
    step();
    prdata = 64'hCAFE;
    cmd(1'b0, 32'h34, 64'h0, 8'h00, 1'b0);
    exp_rsp(64'hCAFE, 1'b0, 1'b0);
    step();
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("to_edge_still_access", 64'(penable), 64'd1);
    step();
    pready = 1'b1;
    step();
    @(negedge clk);
    chk("to_edge_rsp_valid", 64'(rsp_valid), 64'd1);
    prdata = '0;

    // out-of-range target
    step();
    cmd(1'b1, 32'h50, 64'h1, 8'hFF, 1'b1);
    exp_rsp(64'h0, 1'b1, 1'b0);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("badtgt_psel", 64'(psel), 64'd0);
    chk("badtgt_penable", 64'(penable), 64'd0);
    chk("badtgt_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("badtgt_ready", 64'(cmd_ready), 64'd1);

    // reset during ACCESS
    step();
    pready = 1'b0;
    cmd(1'b1, 32'h60, 64'h7, 8'hFF, 1'b0);
    step();
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_penable", 64'(penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", 64'(psel), 64'd0);
    chk("arst_penable", 64'(penable), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pready = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", 64'(cmd_ready), 64'd1);
    chk("arst_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
